wb_mem_arbiter: RTL and testbench
=================================

// Module: wb_mem_arbiter
// PURPOSE
//  Two-master round-robin Wishbone arbiter in soc_top that shares the main RAM slave between
//  the CPU data bus (master 0) and the Ethernet DMA master port wb_ethm_* (master 1).
//  A master keeps the grant for as long as it holds cyc, so locked bursts are never split.
//  Slave-side signals are driven from registered grant state only.
// PARAMETERS
//  ADR_WIDTH       32   address width on all ports
//  TIMEOUT_CYCLES  255  stb-without-ack cycles before forced err (WB_ARB_TIMEOUT_EN only)
// PORTS
//  wb_clk_i               in   1          system clock
//  wb_rst_i               in   1          synchronous active-high reset
//  m0_adr_i/m1_adr_i      in   ADR_WIDTH  master address
//  m0_dat_i/m1_dat_i      in   32         master write data
//  m0_dat_o/m1_dat_o      out  32         read data, s_dat_i broadcast to both
//  m0_sel_i/m1_sel_i      in   4          byte selects
//  m0_we_i/m1_we_i        in   1          write enable
//  m0_cyc_i/m1_cyc_i      in   1          bus request / cycle
//  m0_stb_i/m1_stb_i      in   1          strobe
//  m0_ack_o/m1_ack_o      out  1          ack, granted master only
//  m0_err_o/m1_err_o      out  1          err, granted master only
//  s_adr_o,s_dat_o        out  ADR_WIDTH,32  muxed to slave
//  s_sel_o,s_we_o         out  4,1        muxed to slave
//  s_cyc_o,s_stb_o        out  1          granted master cyc/stb, gated by grant
//  s_dat_i,s_ack_i,s_err_i in  32,1,1     slave response
//  grant_o                out  2          one-hot current grant (debug/trace)
// BEHAVIOUR
//  - FSM IDLE/GNT0/GNT1. Reset: IDLE, grant_o=0, last_grant=1 (m0 wins first), all s_*, ack, err = 0.
//  - IDLE: if any cyc high, grant next cycle. Both high -> the master != last_grant. One high -> that master.
//    Latency: cyc at cycle N -> s_cyc_o at N+1.
//  - GNTx: s_* = master x signals. mx_ack_o = s_ack_i and mx_err_o = s_err_i, combinational.
//    The other master sees ack=err=0.
//  - GNTx and mx_cyc_i falls: if the other master's cyc is high, go straight to GNT(other) with no idle cycle.
//    Otherwise go to IDLE. last_grant <= x on every release.
//  - Grant changes only on a registered edge. s_cyc_o/s_stb_o are never high for the non-granted master.
//  - Simultaneous release by x and request by y in the same cycle: handover to y as above.
//  - Reset asserted mid-transfer: next cycle IDLE, all outputs 0. Pending slave ack is ignored.
//  - m*_dat_o = s_dat_i always. Masters qualify it with their own ack.
// CONFIGURATION
//  WB_ARB_TIMEOUT_EN defined:
//   - 8-bit counter clears on s_ack_i|s_err_i|!s_stb_o and increments while s_stb_o is high.
//   - When the count reaches TIMEOUT_CYCLES: granted master gets err_o=1 for exactly one cycle,
//     s_stb_o is forced 0 in that cycle, and the counter clears.
//  Undefined: no counter; a stalled slave holds the grant indefinitely.
// STRUCTURE
//  - Shared package/include wb_arb_defs.v holds the state encodings ARB_IDLE=2'd0, ARB_GNT0=2'd1, ARB_GNT1=2'd2
//    and the grant index constants.
//  - One sub-module, wb_arb_rr2: the 2-way round-robin pick (req[1:0], last -> gnt[1:0]), combinational.
//    Mux, FSM and timeout stay in the top.
// TESTING
//  1 Reset, then m0_cyc=m1_cyc=1 in the same cycle -> grant_o=2'b01 at N+1.
//    m0 releases -> grant_o=2'b10 next cycle, no IDLE gap.
//  2 m1 4-beat burst, adr 0x100..0x10C, cyc held, m0 requests mid-burst ->
//    m0 is not granted until m1 drops cyc. All 4 m1 acks seen, m0_ack_o=0 throughout.
//  3 m0 write 0xDEADBEEF, sel=4'b0011, to 0x40 -> s_dat_o/s_sel_o match.
//    m1 read of 0x40 returns the slave data on m1_dat_o with m1_ack_o only.
//  4 wb_rst_i=1 while GNT1 with s_stb_o=1 -> next cycle grant_o=0, s_cyc_o=0.
//    First grant after reset goes to m0.
//  5 s_err_i=1 on an m0 access -> m0_err_o=1, m1_err_o=0, grant held until m0_cyc_i=0.
//  6 WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks ->
//    m0_err_o pulses once 8 cycles after stb; without the macro, no err ever appears.

Source files
------------

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone RAM arbiter:
// FSM state encodings and master index constants.
package wb_mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE = 2'd0;
    localparam logic [1:0] ARB_GNT0 = 2'd1;
    localparam logic [1:0] ARB_GNT1 = 2'd2;

    localparam logic GNT_IDX_M0 = 1'b0;
    localparam logic GNT_IDX_M1 = 1'b1;

endpackage

// File: rtl/wb_arb_rr2.sv
// Two-way round-robin pick: when both masters request, the one that
// did not hold the bus last wins.
module wb_arb_rr2
    import wb_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last == GNT_IDX_M1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin Wishbone arbiter sharing the main RAM between the CPU (m0) and Ethernet DMA (m1).
// Optional stall timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADR_WIDTH = 32
`ifdef WB_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,

    input  logic [ADR_WIDTH-1:0] m0_adr_i,
    input  logic [31:0]          m0_dat_i,
    output logic [31:0]          m0_dat_o,
    input  logic [3:0]           m0_sel_i,
    input  logic                 m0_we_i,
    input  logic                 m0_cyc_i,
    input  logic                 m0_stb_i,
    output logic                 m0_ack_o,
    output logic                 m0_err_o,

    input  logic [ADR_WIDTH-1:0] m1_adr_i,
    input  logic [31:0]          m1_dat_i,
    output logic [31:0]          m1_dat_o,
    input  logic [3:0]           m1_sel_i,
    input  logic                 m1_we_i,
    input  logic                 m1_cyc_i,
    input  logic                 m1_stb_i,
    output logic                 m1_ack_o,
    output logic                 m1_err_o,

    output logic [ADR_WIDTH-1:0] s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic [31:0]          s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,

    output logic [1:0]           grant_o
);

    logic [1:0] state;
    logic       last_grant;
    logic [1:0] rr_gnt;
    logic       gnt0;
    logic       gnt1;
    logic       stb_raw;
    logic       timeout_hit;

    wb_arb_rr2 u_rr (
        .req  ({m1_cyc_i, m0_cyc_i}),
        .last (last_grant),
        .gnt  (rr_gnt)
    );

    // A grant is only released when its owner drops cyc; handover skips IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= ARB_IDLE;
            last_grant <= GNT_IDX_M1;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (rr_gnt[0]) begin
                        state <= ARB_GNT0;
                    end else if (rr_gnt[1]) begin
                        state <= ARB_GNT1;
                    end
                end
                ARB_GNT0: begin
                    if (!m0_cyc_i) begin
                        last_grant <= GNT_IDX_M0;
                        state      <= m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
                    end
                end
                ARB_GNT1: begin
                    if (!m1_cyc_i) begin
                        last_grant <= GNT_IDX_M1;
                        state      <= m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign gnt0    = (state == ARB_GNT0);
    assign gnt1    = (state == ARB_GNT1);
    assign grant_o = {gnt1, gnt0};

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        stb_raw = 1'b0;
        if (gnt0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            stb_raw = m0_stb_i;
        end else if (gnt1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            stb_raw = m1_stb_i;
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] to_cnt;

    assign timeout_hit = stb_raw && (to_cnt == 8'(TIMEOUT_CYCLES));

    // Counts consecutive strobed cycles with no slave response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || s_ack_i || s_err_i || !s_stb_o) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign s_stb_o  = stb_raw & ~timeout_hit;

    assign m0_ack_o = gnt0 & s_ack_i;
    assign m1_ack_o = gnt1 & s_ack_i;
    assign m0_err_o = gnt0 & (s_err_i | timeout_hit);
    assign m1_err_o = gnt1 & (s_err_i | timeout_hit);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: directed scenarios plus randomized
// traffic against a grant-ownership reference model.
module tb_wb_mem_arbiter;

    localparam int unsigned AW = 32;

    logic          wb_clk_i;
    logic          wb_rst_i;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [31:0]   m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
    logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]    grant_o;

    int checks = 0;
    int failures = 0;

    // Reference model: which master owns the bus (-1 none) and who released last.
    int owner = -1;
    int last_owner = 1;

    wb_mem_arbiter #(
        .ADR_WIDTH (AW)
`ifdef WB_ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .wb_clk_i (wb_clk_i), .wb_rst_i (wb_rst_i),
        .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_dat_o (m0_dat_o),
        .m0_sel_i (m0_sel_i), .m0_we_i (m0_we_i), .m0_cyc_i (m0_cyc_i),
        .m0_stb_i (m0_stb_i), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_dat_o (m1_dat_o),
        .m1_sel_i (m1_sel_i), .m1_we_i (m1_we_i), .m1_cyc_i (m1_cyc_i),
        .m1_stb_i (m1_stb_i), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_adr_o (s_adr_o), .s_dat_o (s_dat_o), .s_sel_o (s_sel_o),
        .s_we_o (s_we_o), .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o),
        .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .s_err_i (s_err_i),
        .grant_o (grant_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            owner      <= -1;
            last_owner <= 1;
        end else if (owner < 0) begin
            if (m0_cyc_i && m1_cyc_i) owner <= 1 - last_owner;
            else if (m0_cyc_i)        owner <= 0;
            else if (m1_cyc_i)        owner <= 1;
        end else if (!(owner == 0 ? m0_cyc_i : m1_cyc_i)) begin
            last_owner <= owner;
            owner      <= (owner == 0 ? m1_cyc_i : m0_cyc_i) ? 1 - owner : -1;
        end
    end

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        wb_rst_i = 1'b1;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1;
        step(); step();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL reset_grant: got %b expected 00", grant_o); end
        checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin failures++; $display("FAIL reset_cyc_stb: got cyc=%b stb=%b expected 0 0", s_cyc_o, s_stb_o); end
        checks++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin failures++; $display("FAIL reset_ack_err: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
        checks++; if (s_adr_o !== '0) begin failures++; $display("FAIL reset_adr: got %h expected 0", s_adr_o); end
        clear_inputs();
        wb_rst_i = 1'b0;
        step();
    endtask

    task automatic test_both_request();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h1000;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h2000;
        #1;
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL both_req_latency: got %b expected 00", grant_o); end
        step();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL both_req_first: got %b expected 01", grant_o); end
        checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h1000) begin failures++; $display("FAIL both_req_mux0: got cyc=%b adr=%h expected 1 00001000", s_cyc_o, s_adr_o); end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL handover_no_gap: got %b expected 10", grant_o); end
        checks++; if (s_cyc_o !== 1'b1 || s_adr_o !== 32'h2000) begin failures++; $display("FAIL handover_mux1: got cyc=%b adr=%h expected 1 00002000", s_cyc_o, s_adr_o); end
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        step();
        checks++; if (grant_o !== 2'b00) begin failures++; $display("FAIL release_idle: got %b expected 00", grant_o); end
    endtask

    task automatic test_burst();
        int acks = 0;
        int m0_acks = 0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h100;
        step();
        for (int i = 0; i < 4; i++) begin
            m1_adr_i = 32'h100 + 32'(4 * i);
            s_ack_i  = 1'b1;
            if (i == 1) begin
                m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h5000;
            end
            #1;
            if (m1_ack_o) acks++;
            if (m0_ack_o) m0_acks++;
            checks++; if (grant_o !== 2'b10 || s_adr_o !== m1_adr_i) begin failures++; $display("FAIL burst_beat%0d: got grant=%b adr=%h expected 10 %h", i, grant_o, s_adr_o, m1_adr_i); end
            step();
        end
        s_ack_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        #1;
        checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL burst_hold: got %b expected 10", grant_o); end
        step();
        checks++; if (grant_o !== 2'b01 || s_adr_o !== 32'h5000) begin failures++; $display("FAIL burst_after: got grant=%b adr=%h expected 01 00005000", grant_o, s_adr_o); end
        checks++; if (acks != 4 || m0_acks != 0) begin failures++; $display("FAIL burst_acks: got m1=%0d m0=%0d expected 4 0", acks, m0_acks); end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        logic [31:0] mem_word;
        logic [31:0] wdata;
        logic [3:0]  wsel;
        mem_word = '0;
        wdata    = 32'hDEADBEEF;
        wsel     = 4'b0011;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_adr_i = 32'h40; m0_dat_i = wdata; m0_sel_i = wsel;
        step();
        checks++; if (s_dat_o !== wdata || s_sel_o !== wsel || s_we_o !== 1'b1 || s_adr_o !== 32'h40) begin failures++; $display("FAIL write_mux: got dat=%h sel=%b we=%b adr=%h expected deadbeef 0011 1 00000040", s_dat_o, s_sel_o, s_we_o, s_adr_o); end
        for (int b = 0; b < 4; b++) if (wsel[b]) mem_word[8*b +: 8] = wdata[8*b +: 8];
        s_ack_i = 1'b1;
        #1;
        checks++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin failures++; $display("FAIL write_ack: got m0=%b m1=%b expected 1 0", m0_ack_o, m1_ack_o); end
        step();
        s_ack_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0;
        step();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 32'h40;
        step();
        s_dat_i = mem_word;
        s_ack_i = 1'b1;
        #1;
        checks++; if (m1_dat_o !== 32'h0000BEEF || s_we_o !== 1'b0 || s_adr_o !== 32'h40) begin failures++; $display("FAIL read_data: got dat=%h we=%b adr=%h expected 0000beef 0 00000040", m1_dat_o, s_we_o, s_adr_o); end
        checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin failures++; $display("FAIL read_ack: got m1=%b m0=%b expected 1 0", m1_ack_o, m0_ack_o); end
        step();
        clear_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        step();
        checks++; if (grant_o !== 2'b10 || s_stb_o !== 1'b1) begin failures++; $display("FAIL rstmid_setup: got grant=%b stb=%b expected 10 1", grant_o, s_stb_o); end
        s_ack_i  = 1'b1;
        wb_rst_i = 1'b1;
        step();
        checks++; if (grant_o !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0 || m1_ack_o !== 1'b0) begin failures++; $display("FAIL rstmid_outputs: got grant=%b cyc=%b stb=%b ack=%b expected 00 0 0 0", grant_o, s_cyc_o, s_stb_o, m1_ack_o); end
        wb_rst_i = 1'b0;
        s_ack_i  = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        step();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL rstmid_first_grant: got %b expected 01", grant_o); end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_err();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h80;
        step();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h90;
        s_err_i  = 1'b1;
        #1;
        checks++; if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin failures++; $display("FAIL err_route: got m0err=%b m1err=%b m1ack=%b expected 1 0 0", m0_err_o, m1_err_o, m1_ack_o); end
        step();
        s_err_i = 1'b0;
        step();
        checks++; if (grant_o !== 2'b01) begin failures++; $display("FAIL err_hold: got %b expected 01", grant_o); end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        step();
        checks++; if (grant_o !== 2'b10) begin failures++; $display("FAIL err_release: got %b expected 10", grant_o); end
        clear_inputs();
        step();
    endtask

    task automatic test_timeout();
        int exp_err;
        int limit;
`ifdef WB_ARB_TIMEOUT_EN
        limit = 16;
`else
        limit = 40;
`endif
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h300;
        step();
        for (int k = 0; k <= limit; k++) begin
`ifdef WB_ARB_TIMEOUT_EN
            exp_err = (k == 8) ? 1 : 0;
`else
            exp_err = 0;
`endif
            checks++;
            if (m0_err_o !== 1'(exp_err) || s_stb_o !== 1'(1 - exp_err) || m1_err_o !== 1'b0) begin
                failures++;
                $display("FAIL timeout_k%0d: got err=%b stb=%b expected %0d %0d", k, m0_err_o, s_stb_o, exp_err, 1 - exp_err);
            end
            step();
        end
        clear_inputs();
        step(); step();
    endtask

    task automatic test_random();
        int streak = 0;
        logic [1:0]  eg;
        logic        ecyc, estb;
        logic [31:0] eadr;
        for (int n = 0; n < 400; n++) begin
            if (m0_cyc_i) begin if ($urandom_range(3) == 0) m0_cyc_i = 1'b0; end
            else if ($urandom_range(2) == 0) m0_cyc_i = 1'b1;
            if (m1_cyc_i) begin if ($urandom_range(3) == 0) m1_cyc_i = 1'b0; end
            else if ($urandom_range(2) == 0) m1_cyc_i = 1'b1;
            m0_stb_i = m0_cyc_i & ($urandom_range(3) != 0);
            m1_stb_i = m1_cyc_i & ($urandom_range(3) != 0);
            m0_adr_i = $urandom; m1_adr_i = $urandom;
            m0_dat_i = $urandom; m1_dat_i = $urandom;
            m0_sel_i = 4'($urandom); m1_sel_i = 4'($urandom);
            m0_we_i  = 1'($urandom_range(1)); m1_we_i = 1'($urandom_range(1));
            s_dat_i  = $urandom;
            eg   = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
            ecyc = (owner == 0) ? m0_cyc_i : (owner == 1) ? m1_cyc_i : 1'b0;
            estb = (owner == 0) ? m0_stb_i : (owner == 1) ? m1_stb_i : 1'b0;
            eadr = (owner == 0) ? m0_adr_i : (owner == 1) ? m1_adr_i : 32'h0;
            s_ack_i = 1'($urandom_range(1));
            s_err_i = !s_ack_i && ($urandom_range(7) == 0);
            // Keep stalls short so the optional timeout never fires here.
            if (estb && !s_ack_i && !s_err_i) streak++; else streak = 0;
            if (streak >= 4) begin s_ack_i = 1'b1; streak = 0; end
            #1;
            checks++; if (grant_o !== eg) begin failures++; $display("FAIL rand_grant n=%0d: got %b expected %b", n, grant_o, eg); end
            checks++; if (s_cyc_o !== ecyc || s_stb_o !== estb) begin failures++; $display("FAIL rand_cyc_stb n=%0d: got %b%b expected %b%b", n, s_cyc_o, s_stb_o, ecyc, estb); end
            checks++; if (s_adr_o !== eadr) begin failures++; $display("FAIL rand_adr n=%0d: got %h expected %h", n, s_adr_o, eadr); end
            checks++; if (m0_ack_o !== (owner == 0 && s_ack_i) || m1_ack_o !== (owner == 1 && s_ack_i)) begin failures++; $display("FAIL rand_ack n=%0d: got m0=%b m1=%b owner=%0d", n, m0_ack_o, m1_ack_o, owner); end
            checks++; if (m0_err_o !== (owner == 0 && s_err_i) || m1_err_o !== (owner == 1 && s_err_i)) begin failures++; $display("FAIL rand_err n=%0d: got m0=%b m1=%b owner=%0d", n, m0_err_o, m1_err_o, owner); end
            checks++; if (m0_dat_o !== s_dat_i || m1_dat_o !== s_dat_i) begin failures++; $display("FAIL rand_rdata n=%0d: got %h %h expected %h", n, m0_dat_o, m1_dat_o, s_dat_i); end
            step();
        end
        clear_inputs();
        step(); step();
    endtask

    initial begin
        clear_inputs();
        wb_rst_i = 1'b1;
        test_reset();
        test_both_request();
        test_burst();
        test_write_read();
        test_reset_mid();
        test_err();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
